// File: rtl/fp_arbiter.sv
// Round-robin arbiter sharing one fpUnit among NUM_REQ effect blocks.
// Latches the grantee's operands and routes done/result back to it only.
module fp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OWNER_W = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_clk_en,
  input  logic [32*NUM_REQ-1:0]  req_dataa,
  input  logic [32*NUM_REQ-1:0]  req_datab,
  input  logic [3*NUM_REQ-1:0]   req_operation,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [31:0]            req_result,
  output logic [31:0]            fp_dataa,
  output logic [31:0]            fp_datab,
  output logic [2:0]             fp_operation,
  output logic                   fp_clk_en,
  input  logic                   fp_done,
  input  logic [31:0]            fp_result,
  output logic                   busy,
  output logic [OWNER_W-1:0]     owner,
  output logic                   timeout_err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t state, state_nx;
  logic [OWNER_W-1:0] rr_ptr, win, idx, rr_nx;
  logic [NUM_REQ-1:0] cand, own_oh;
  logic               found, grant, tmo, done_hit;
  logic [31:0]        a_q, b_q;
  logic [2:0]         op_q;
  logic [WD_W-1:0]    wd, wd_now;
  logic               tmo_hit;

  logic [31:0] a_arr [NUM_REQ];
  logic [31:0] b_arr [NUM_REQ];
  logic [2:0]  o_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign a_arr[g] = req_dataa[32*g +: 32];
    assign b_arr[g] = req_datab[32*g +: 32];
    assign o_arr[g] = req_operation[3*g +: 3];
  end

  // Previous owner sits out the RELEASE cycle so others get a turn.
  always_comb begin
    cand  = req_clk_en;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    if (state == RELEASE) cand[owner] = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = OWNER_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign rr_nx   = OWNER_W'((int'(win) + 1) % NUM_REQ);
  assign wd_now  = wd + 1'b1;
  assign tmo_hit = (TIMEOUT != 0) && (wd_now == WD_MAX);
  assign own_oh  = NUM_REQ'(1) << owner;

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    tmo      = 1'b0;
    done_hit = 1'b0;
    unique case (state)
      IDLE, RELEASE: begin
        if (found) begin
          state_nx = BUSY;
          grant    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        if (fp_done) begin
          done_hit = 1'b1;
          state_nx = RELEASE;
        end else if (!req_clk_en[owner]) begin
          state_nx = IDLE;
        end else if (tmo_hit) begin
          tmo      = 1'b1;
          done_hit = 1'b1;
          state_nx = RELEASE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= '0;
      rr_ptr      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner  <= win;
        rr_ptr <= rr_nx;
        a_q    <= a_arr[win];
        b_q    <= b_arr[win];
        op_q   <= o_arr[win];
        wd     <= '0;
      end else if (state == BUSY) begin
        wd <= wd_now;
      end
      if (tmo) timeout_err <= 1'b1;
    end
  end

  assign busy         = (state == BUSY);
  assign fp_clk_en    = (state == BUSY);
  assign fp_dataa     = a_q;
  assign fp_datab     = b_q;
  assign fp_operation = op_q;
  assign req_done     = done_hit ? own_oh : '0;
  assign req_result   = tmo ? 32'h0 : fp_result;

endmodule
